// File: rtl/bsk_prd_multi.sv
// Purpose: CH_NUM x 16-bit command receiver with per-bit debounce, sticky change flags, indication and ID registers on an async host bus.
// Latency: reads combinational; writes commit at the 3rd clk edge after iWr falls; filt follows iCom after 2+FILT_LEN edges (2 without filter).
// Backpressure: none; the host holds iWr low for at least 4 clk cycles with iA/iCS/bD stable.
// Build option: define BSK_PRD_FILT_EN to compile in the debounce counters; otherwise filt is the synchronised input.
module bsk_prd_multi #(
    parameter logic [6:0] VERSION  = 7'h25,
    parameter logic [7:0] PASSWORD = 8'hA4,
    parameter logic [3:0] CS       = 4'b1011,
    parameter int         CH_NUM   = 2,
    parameter int         FILT_LEN = 4,
    parameter int         TEST_DIV = 8
) (
    input  logic                  clk,
    input  logic                  iRes,
    input  logic [3:0]            iCS,
    input  logic [3:0]            iA,
    input  logic                  iRd,
    input  logic                  iWr,
    inout  wire  [15:0]           bD,
    input  logic [16*CH_NUM-1:0]  iCom,
    input  logic                  iBl,
    output logic [16*CH_NUM-1:0]  oComInd,
    output logic                  oCS,
    output logic                  test
);

    localparam int CW    = 16 * CH_NUM;
    localparam int DIV_W = (TEST_DIV > 2) ? $clog2(TEST_DIV) : 1;

    // Parameter sanity: an illegal configuration stops elaboration.
    if (CH_NUM < 1 || CH_NUM > 4 || FILT_LEN < 1 || FILT_LEN > 16 ||
        TEST_DIV < 2 || (TEST_DIV % 2) != 0) begin : gParamErr
        $error("bsk_prd_multi: illegal parameter set");
    end

    // One sample of the host bus, carried through the two-stage synchroniser.
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [3:0]  cs;
        logic [3:0]  a;
        logic [15:0] d;
    } busSmp_t;

    localparam busSmp_t BUS_IDLE = '{wr: 1'b1, rd: 1'b1, cs: 4'h0, a: 4'h0, d: 16'h0000};

    busSmp_t          busS1, busS2;
    logic [1:0]       stgVld;      // stage contents come from the pins, not from reset
    logic             wrQual;
    logic             wrQualPrev;
    logic             wrCommit;

    logic [CW-1:0]    comS1, comS2;
    logic [CW-1:0]    filtV;
    logic [CW-1:0]    filtPrev;
    logic [CW-1:0]    indV;
    logic [CH_NUM-1:0] chg;
    logic [CH_NUM-1:0] chgFlag;
    logic             testEn;
    logic             divEn;
    logic [DIV_W-1:0] cnt;
    logic [15:0]      rdData;
    logic             csHit;

    assign csHit   = (iCS == CS);
    assign oCS     = ~csHit;
    assign bD      = (csHit && !iRd) ? rdData : 16'hzzzz;
    assign oComInd = ~indV;
    assign divEn   = testEn & iBl;

    // Host bus synchroniser; strobes park inactive on reset.
    always_ff @(posedge clk) begin
        if (iRes) begin
            busS1  <= BUS_IDLE;
            busS2  <= BUS_IDLE;
            stgVld <= 2'b00;
        end else begin
            busS1  <= '{wr: iWr, rd: iRd, cs: iCS, a: iA, d: bD};
            busS2  <= busS1;
            stgVld <= {stgVld[0], 1'b1};
        end
    end

    // A write needs the strobe seen inactive first, so a write cut by reset never commits late.
    assign wrQual   = !busS2.wr && busS2.rd && (busS2.cs == CS);
    assign wrCommit = stgVld[1] && wrQual && !wrQualPrev;

    // Remember the qualified strobe; treat stale reset-fill stages as already active.
    always_ff @(posedge clk) begin
        if (iRes) begin
            wrQualPrev <= 1'b1;
        end else begin
            wrQualPrev <= stgVld[1] ? wrQual : 1'b1;
        end
    end

    // Command input synchroniser.
    always_ff @(posedge clk) begin
        if (iRes) begin
            comS1 <= '0;
            comS2 <= '0;
        end else begin
            comS1 <= iCom;
            comS2 <= comS1;
        end
    end

`ifdef BSK_PRD_FILT_EN
    localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FCNT_W-1:0] fCnt [CW];
    logic [CW-1:0]     filtReg;

    // Per-bit debounce: a new level must persist FILT_LEN cycles before filt accepts it.
    always_ff @(posedge clk) begin
        if (iRes) begin
            filtReg <= '0;
            for (int i = 0; i < CW; i++) fCnt[i] <= '0;
        end else begin
            for (int i = 0; i < CW; i++) begin
                if (comS2[i] == filtReg[i]) begin
                    fCnt[i] <= '0;
                end else if (fCnt[i] == FCNT_W'(FILT_LEN - 1)) begin
                    filtReg[i] <= comS2[i];
                    fCnt[i]    <= '0;
                end else begin
                    fCnt[i] <= fCnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    assign filtV = filtReg;
`else
    assign filtV = comS2;
`endif

    // Per-channel change detect against last cycle's filtered word.
    always_comb begin
        chg = '0;
        for (int x = 0; x < CH_NUM; x++) begin
            chg[x] = |(filtV[16*x +: 16] ^ filtPrev[16*x +: 16]);
        end
    end

    // Sticky change flags (set beats a same-cycle W1C) and the delayed filt copy.
    always_ff @(posedge clk) begin
        if (iRes) begin
            filtPrev <= '0;
            chgFlag  <= '0;
        end else begin
            filtPrev <= filtV;
            for (int x = 0; x < CH_NUM; x++) begin
                if (chg[x]) begin
                    chgFlag[x] <= 1'b1;
                end else if (wrCommit && busS2.a == 4'h8 && busS2.d[x]) begin
                    chgFlag[x] <= 1'b0;
                end
            end
        end
    end

    // Host-writable registers: indication words and the test enable.
    always_ff @(posedge clk) begin
        if (iRes) begin
            indV   <= '0;
            testEn <= 1'b0;
        end else if (wrCommit) begin
            for (int x = 0; x < CH_NUM; x++) begin
                if (busS2.a == 4'(4 + x)) indV[16*x +: 16] <= busS2.d;
            end
            if (busS2.a == 4'h9) testEn <= busS2.d[0];
        end
    end

    // Test divider: free-running while enabled and unblocked, registered output.
    always_ff @(posedge clk) begin
        if (iRes) begin
            cnt  <= '0;
            test <= 1'b0;
        end else begin
            if (!divEn) begin
                cnt <= '0;
            end else if (cnt == DIV_W'(TEST_DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            test <= divEn && (cnt >= DIV_W'(TEST_DIV / 2));
        end
    end

    // Combinational read mux straight from the raw address.
    always_comb begin
        rdData = 16'h0000;
        for (int x = 0; x < CH_NUM; x++) begin
            if (iA == 4'(x))     rdData = filtV[16*x +: 16];
            if (iA == 4'(4 + x)) rdData = indV[16*x +: 16];
        end
        if (iA == 4'h8) rdData = 16'(chgFlag);
        if (iA == 4'h9) rdData = {PASSWORD, VERSION, testEn};
    end

endmodule

// File: tb/tb_bsk_prd_multi.sv
// Directed bench for bsk_prd_multi with default parameters (CH_NUM=2, FILT_LEN=4, TEST_DIV=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Expectations follow the build: BSK_PRD_FILT_EN selects debounced or direct filter timing.
module tb_bsk_prd_multi;

    localparam logic [3:0] CS_CODE = 4'b1011;

`ifdef BSK_PRD_FILT_EN
    localparam int          FLAT     = 6;        // edge at which filt first shows a new input
    localparam int          LEAD     = 4;        // iCom-to-iWr offset so flag set meets the clear
    localparam logic [15:0] FLAG_EXP = 16'h0001; // ch1 pulse rejected
`else
    localparam int          FLAT     = 2;
    localparam int          LEAD     = 0;
    localparam logic [15:0] FLAG_EXP = 16'h0003; // ch1 pulse passed through
`endif

    logic        clk = 1'b0;
    logic        iRes, iRd, iWr, iBl;
    logic [3:0]  iCS, iA;
    logic [31:0] iCom;
    logic [31:0] oComInd;
    logic        oCS, test;
    logic [15:0] hostD;
    logic        hostDrv;
    wire  [15:0] bD;

    int totalN = 0;
    int badN   = 0;

    assign bD = hostDrv ? hostD : 16'hzzzz;

    always #5 clk = ~clk;

    bsk_prd_multi dut (
        .clk     (clk),
        .iRes    (iRes),
        .iCS     (iCS),
        .iA      (iA),
        .iRd     (iRd),
        .iWr     (iWr),
        .bD      (bD),
        .iCom    (iCom),
        .iBl     (iBl),
        .oComInd (oComInd),
        .oCS     (oCS),
        .test    (test)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalN++;
        if (got !== exp) begin
            badN++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [15:0] data);
        iCS = CS_CODE;
        iA  = addr;
        iRd = 1'b0;
        #1;
        data = bD;
        iRd  = 1'b1;
        #1;
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [15:0] data, input logic [3:0] cs);
        iCS     = cs;
        iA      = addr;
        hostD   = data;
        hostDrv = 1'b1;
        iWr     = 1'b0;
        tick(4);
        iWr = 1'b1;
        tick(3);
        hostDrv = 1'b0;
        iCS     = CS_CODE;
    endtask

    initial begin
        logic [15:0] rd;
        int rises, highs, firstRise;
        logic prevT;

        iRes = 1'b1; iRd = 1'b1; iWr = 1'b1; iBl = 1'b1;
        iCS = CS_CODE; iA = 4'h0; iCom = '0; hostD = '0; hostDrv = 1'b0;

        // Reset and ID
        tick(3);
        busRead(4'h9, rd); chk("id_in_reset", {16'h0, rd}, 32'h0000A44A);
        chk("ocs_match", {31'h0, oCS}, 32'h0);
        iCS = 4'b0000; #1; chk("ocs_0000", {31'h0, oCS}, 32'h1);
        iCS = 4'b1010; #1; chk("ocs_1010", {31'h0, oCS}, 32'h1);
        iCS = CS_CODE;
        iRes = 1'b0;
        tick(1);
        busRead(4'h8, rd); chk("flags_rst", {16'h0, rd}, 32'h0);
        chk("ind_rst", oComInd, 32'hFFFFFFFF);
        chk("test_rst", {31'h0, test}, 32'h0);
        busRead(4'hF, rd); chk("unused_addr", {16'h0, rd}, 32'h0);

        // Indication write, channel 0
        busWrite(4'h4, 16'h9231, CS_CODE);
        chk("ind0_wr", {16'h0, oComInd[15:0]}, 32'h00006DCE);
        chk("ind1_keep", {16'h0, oComInd[31:16]}, 32'h0000FFFF);
        busRead(4'h4, rd); chk("ind0_rd", {16'h0, rd}, 32'h00009231);

        // Wrong chip select: ignored
        busWrite(4'h4, 16'h1234, 4'b0000);
        chk("cs_miss", {16'h0, oComInd[15:0]}, 32'h00006DCE);

        // Channel 1 write, commit edge
        iCS = CS_CODE; iA = 4'h5; hostD = 16'h00F0; hostDrv = 1'b1; iWr = 1'b0;
        tick(2); chk("wr_edge2", {16'h0, oComInd[31:16]}, 32'h0000FFFF);
        tick(1); chk("wr_edge3", {16'h0, oComInd[31:16]}, 32'h0000FF0F);
        tick(1); iWr = 1'b1; tick(3); hostDrv = 1'b0;
        busRead(4'h5, rd); chk("ind1_rd", {16'h0, rd}, 32'h000000F0);

        // Filter latency on channel 0
        iCom[15:0] = 16'h1331;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            busRead(4'h0, rd);
            chk($sformatf("filt_e%0d", k), {16'h0, rd}, (k < FLAT) ? 32'h0 : 32'h00001331);
        end

`ifdef BSK_PRD_FILT_EN
        // Short pulse on channel 1 is rejected
        iCom[16] = 1'b1; tick(3); iCom[16] = 1'b0;
        tick(10);
        busRead(4'h1, rd); chk("pulse_rej", {16'h0, rd}, 32'h0);
`else
        // One-cycle pulse on channel 1 passes straight through
        iCom[16] = 1'b1; tick(1); iCom[16] = 1'b0;
        tick(1); busRead(4'h1, rd); chk("pulse_on", {16'h0, rd}, 32'h00000001);
        tick(1); busRead(4'h1, rd); chk("pulse_off", {16'h0, rd}, 32'h0);
        tick(4);
`endif

        // Change flags
        busRead(4'h8, rd); chk("flags_set", {16'h0, rd}, {16'h0, FLAG_EXP});
        // Read and write strobes together: W1C of the driven flag value must not commit
        iCS = CS_CODE; iA = 4'h8; hostDrv = 1'b0; iRd = 1'b0; iWr = 1'b0;
        tick(5);
        iWr = 1'b1; iRd = 1'b1;
        tick(3);
        busRead(4'h8, rd); chk("rd_prio", {16'h0, rd}, {16'h0, FLAG_EXP});
        busWrite(4'h8, 16'h0003, CS_CODE);
        busRead(4'h8, rd); chk("flags_clr", {16'h0, rd}, 32'h0);
        // New change lands on the clear commit edge: set wins
        iCom[15:0] = 16'h0000;
        tick(LEAD);
        busWrite(4'h8, 16'h0001, CS_CODE);
        busRead(4'h8, rd); chk("set_wins", {16'h0, rd}, 32'h00000001);

        // Test divider
        iBl = 1'b1;
        busWrite(4'h9, 16'h0001, CS_CODE);
        busRead(4'h9, rd); chk("id_en", {16'h0, rd}, 32'h0000A44B);
        rises = 0; highs = 0; firstRise = 0; prevT = test;
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (test && !prevT) begin
                rises++;
                if (firstRise == 0) firstRise = i;
            end
            if (test) highs++;
            prevT = test;
        end
        chk("test_rises", rises, 32'd3);
        chk("test_first", firstRise, 32'd1);
        chk("test_duty", highs, 32'd12);
        tick(2); chk("test_hi", {31'h0, test}, 32'h1);
        iBl = 1'b0;
        tick(1); chk("test_blk", {31'h0, test}, 32'h0);
        iBl = 1'b1; iRes = 1'b1;
        tick(1); iRes = 1'b0;
        tick(12); chk("test_rst_off", {31'h0, test}, 32'h0);
        busRead(4'h9, rd); chk("id_after_rst", {16'h0, rd}, 32'h0000A44A);

        // Reset in the middle of a write: dropped, no late commit
        iCS = CS_CODE; iA = 4'h4; hostD = 16'h5555; hostDrv = 1'b1; iWr = 1'b0;
        tick(1); iRes = 1'b1;
        tick(1); iRes = 1'b0;
        tick(5); iWr = 1'b1;
        tick(3); hostDrv = 1'b0;
        chk("rst_mid_wr", oComInd, 32'hFFFFFFFF);
        busRead(4'h4, rd); chk("rst_mid_rd", {16'h0, rd}, 32'h0);

        $display("test done: total=%0d bad=%0d", totalN, badN);
        $finish;
    end

endmodule

// File: doc/bsk_prd_multi.md
# bsk_prd_multi

Parametrised multi-channel successor of the BSK PRD command-receiver block. It takes CH_NUM groups of 16 discrete command inputs and synchronises and debounces each bit, then exposes the filtered words, sticky per-channel change flags, per-channel command-indication registers and an ID/control register on the asynchronous 16-bit host bus. All state is clocked on clk, and bus strobes are synchronised into the clk domain. A gated test-frequency output is generated from clk.

## Interface
- VERSION, 7'h25, firmware version reported in the ID register.
- PASSWORD, 8'hA4, constant reported in the ID register.
- CS, 4'b1011, chip-select code matched on iCS.
- CH_NUM, 2, number of 16-bit command channels; legal range 1..4.
- FILT_LEN, 4, debounce length in clk cycles; legal range 1..16.
- TEST_DIV, 8, test output period in clk cycles; even, ≥2.
- clk  in  1  system clock.
- iRes  in  1  reset, synchronous, active-high.
- iCS  in  4  chip-select code.
- iA  in  4  register address.
- iRd  in  1  read strobe, active-low.
- iWr  in  1  write strobe, active-low.
- bD  inout  16  host data bus.
- iCom  in  16*CH_NUM  raw command inputs; channel k is iCom[16k+15:16k].
- iBl  in  1  block input, active-low; 0 forces test low.
- oComInd  out  16*CH_NUM  command indication, active-low; equals ~ind[k].
- oCS  out  1  0 when iCS==CS, else 1 (combinational).
- test  out  1  divided test frequency.

## Operation
- Register map (x = 0..CH_NUM-1):
  - 0x0+x: filt[x], read-only.
  - 0x4+x: ind[x], read/write.
  - 0x8: change flags [CH_NUM-1:0], write-1-to-clear; upper bits read 0.
  - 0x9: {PASSWORD, VERSION, test_en}; a write affects only bit0.
  - Unused or out-of-range addresses read 0x0000; writes to them are ignored.
- Read path is combinational. bD drives the addressed register when iCS==CS and iRd=0; otherwise bD is Z.
- iRd=0 has priority over iWr=0: no write commits while iRd is low.
- Write path:
  - iWr, iRd, iCS, iA and bD pass through a two-stage synchroniser.
  - A write commits once, on the first cycle the second stage shows iWr=0, iRd=1 and CS matched, after a cycle where it did not.
  - Address and data are taken from the second synchroniser stage.
- Command filter, per bit:
  - Two-flop synchroniser, then a counter.
  - The counter clears while the synced value equals filt.
  - The counter increments while the synced value differs from filt.
  - When the counter equals FILT_LEN-1 and the value still differs: filt takes the new value and the counter clears.
- Change flag x sets in the cycle after any bit of filt[x] changes. When a set and a W1C clear land on the same cycle, the set wins.
- Test divider:
  - Counter cnt runs 0..TEST_DIV-1 and wraps, only while test_en=1 and iBl=1; otherwise cnt is held at 0.
  - test is registered: test = enabled && (cnt ≥ TEST_DIV/2).
- Reset (iRes=1 at a clk edge) clears:
  - ind, so oComInd is all ones;
  - filt, all counters, all flags, test_en, cnt and test;
  - synchroniser strobe stages to inactive (1).
- Reads stay functional during reset and return reset values (0x9 reads 0xA44A with default parameters).
- Reset mid-write: the write is dropped, and no write commits until the strobe is seen inactive again.

## Timing
- Read: bD is valid one combinational delay after iA/iCS/iRd settle; no clk dependency.
- Write: commits at the 3rd clk edge after iWr falls. oComInd updates at that edge.
- Host requirement: iWr low ≥4 clk cycles; iA, iCS and bD stable throughout.
- Filter latency: filt changes at clk edge 2+FILT_LEN after the input change. Pulses shorter than FILT_LEN cycles are rejected.
- Flag latency: one edge after the filt change.
- test:
  - After enable, the first rising edge occurs TEST_DIV/2+1 edges later; period TEST_DIV, 50% duty.
  - Goes low the edge after iBl=0 or after test_en is cleared.

## Configuration
- BSK_PRD_FILT_EN defined: the debounce filter is compiled in, as described above.
- BSK_PRD_FILT_EN undefined:
  - filt = second synchroniser stage directly, latency 2 edges;
  - FILT_LEN is ignored and no counters are built;
  - change flags still operate.

## Test plan
- Reset/ID: pulse iRes → read 0x9 = 0xA44A; read 0x8 = 0x0000; oComInd = 32'hFFFFFFFF; test=0; oCS=0 only for iCS=4'b1011.
- Write: write 0x9231 to 0x4, iWr low 4 cycles → oComInd[15:0]=0x6DCE, oComInd[31:16]=0xFFFF, read 0x4 = 0x9231. Repeat with iCS=4'b0000 → no change. Repeat with iRd=0 and iWr=0 together → no change.
- Filter (FILT_LEN=4, macro on):
  - iCom[15:0] 0→0x1331 → read 0x0 is 0x0000 through edge 5 and 0x1331 from edge 6;
  - a 3-cycle pulse on iCom[16] → filt[1] stays 0.
- Flags: after the filter test, 0x8 = 0x0001 → write 0x0001 to 0x8 → reads 0x0000. A new filt change coinciding with the clear commit → reads 0x0001.
- Test signal (TEST_DIV=8): iBl=1, write 0x0001 to 0x9 → 3 rising edges of test in 24 cycles. iBl=0 → test=0 next edge. iRes=1 → test_en=0, test stays 0 after iBl=1.
- Macro off: iCom change reaches read 0x0 at edge 2, and a 1-cycle pulse is passed through.
